// File: rtl/enemy_pkg.sv
// Shared types and screen constants for the enemy row and its helpers.
package enemy_pkg;

    localparam int unsigned PIX_W    = 10;
    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    typedef logic [PIX_W-1:0] pix_t;

    typedef enum logic [4:0] {
        ST_ERROR   = 5'b00000,
        ST_IDLE    = 5'b00001,
        ST_RIGHT   = 5'b00010,
        ST_LEFT    = 5'b00100,
        ST_LANDED  = 5'b01000,
        ST_CLEARED = 5'b10000
    } state_e;

endpackage

// File: rtl/priority_scan.sv
// Lowest/highest set bit of a vector plus circular first-set-at-or-after search.
module priority_scan #(
    parameter int unsigned WIDTH_P = 8,
    parameter int unsigned IDX_W_P = (WIDTH_P > 1) ? $clog2(WIDTH_P) : 1
) (
    input  logic [WIDTH_P-1:0] vec_i,
    input  logic [IDX_W_P-1:0] ptr_i,
    output logic [IDX_W_P-1:0] lo_o,
    output logic [IDX_W_P-1:0] hi_o,
    output logic [IDX_W_P-1:0] first_o
);

    logic [WIDTH_P-1:0] rot;
    logic [IDX_W_P-1:0] off;
    logic [IDX_W_P:0]   sum;

    always_comb begin
        lo_o = '0;
        hi_o = '0;
        off  = '0;
        for (int unsigned i = 0; i < WIDTH_P; i++) begin
            if (vec_i[i]) hi_o = IDX_W_P'(i);
        end
        for (int unsigned i = WIDTH_P; i > 0; i--) begin
            if (vec_i[i-1]) lo_o = IDX_W_P'(i - 1);
        end
        // Rotate so the pointer lands on bit 0, then take the lowest set offset.
        rot = WIDTH_P'({vec_i, vec_i} >> ptr_i);
        for (int unsigned i = WIDTH_P; i > 0; i--) begin
            if (rot[i-1]) off = IDX_W_P'(i - 1);
        end
        sum = {1'b0, ptr_i} + {1'b0, off};
        if (sum >= (IDX_W_P + 1)'(WIDTH_P)) sum = sum - (IDX_W_P + 1)'(WIDTH_P);
        first_o = sum[IDX_W_P-1:0];
    end

endmodule

// File: rtl/enemy_row.sv
// Row of invaders moving as one group: edge bounce, descend, speed-up, round-robin fire.
module enemy_row
    import enemy_pkg::*;
#(
    parameter int unsigned NUM_SHIPS_P       = 8,
    parameter int unsigned SHIP_W_P          = 40,
    parameter int unsigned SHIP_H_P          = 10,
    parameter int unsigned GAP_P             = 20,
    parameter int unsigned STEP_X_P          = 10,
    parameter int unsigned STEP_Y_P          = 10,
    parameter int unsigned SCREEN_W_P        = SCREEN_W,
    parameter int unsigned LAND_Y_P          = 440,
    parameter pix_t        TOP_START_P       = 10'd9,
    parameter pix_t        LEFT_START_P      = 10'd9,
    parameter int unsigned FRAMES_PER_STEP_P = 30,
    parameter int unsigned MIN_FRAMES_P      = 4,
    parameter logic [15:0] FIRE_DELAY_P      = 16'd60,
    parameter logic [11:0] COLOR_P           = 12'hFFF
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   frame_i,
    input  logic                   start_i,
    input  logic [NUM_SHIPS_P-1:0] hit_i,
    output logic [9:0]             left_pos_o,
    output logic [9:0]             top_pos_o,
    output logic [9:0]             bot_pos_o,
    output logic [NUM_SHIPS_P-1:0] alive_o,
    output logic                   landed_o,
    output logic                   all_dead_o,
    output logic                   fire_o,
    output logic [9:0]             fire_x_o,
    output logic [9:0]             fire_y_o,
    output logic [3:0]             red_o,
    output logic [3:0]             green_o,
    output logic [3:0]             blue_o
);

    localparam int unsigned PITCH = SHIP_W_P + GAP_P;
    localparam int unsigned IDX_W = (NUM_SHIPS_P > 1) ? $clog2(NUM_SHIPS_P) : 1;

    state_e                 state_q, state_d;
    pix_t                   left_q, left_d, top_q, top_d;
    logic [NUM_SHIPS_P-1:0] alive_q, alive_d;
    logic [15:0]            frame_cnt_q, frame_cnt_d, fire_cnt_q, fire_cnt_d;
    logic [IDX_W-1:0]       fire_ptr_q, fire_ptr_d;
    logic                   landed_q, landed_d, all_dead_q, all_dead_d, fire_q, fire_d;
    pix_t                   fire_x_q, fire_x_d, fire_y_q, fire_y_d;

    logic [IDX_W-1:0] lo_idx, hi_idx, first_idx;
    logic [31:0]      live_cnt, period;
    logic             step, descend;
    pix_t             bot;

    priority_scan #(
        .WIDTH_P (NUM_SHIPS_P),
        .IDX_W_P (IDX_W)
    ) u_scan (
        .vec_i   (alive_q),
        .ptr_i   (fire_ptr_q),
        .lo_o    (lo_idx),
        .hi_o    (hi_idx),
        .first_o (first_idx)
    );

    assign bot = top_q + pix_t'(SHIP_H_P);

    always_comb begin
        state_d     = state_q;
        left_d      = left_q;
        top_d       = top_q;
        alive_d     = alive_q;
        frame_cnt_d = frame_cnt_q;
        fire_cnt_d  = fire_cnt_q;
        fire_ptr_d  = fire_ptr_q;
        fire_d      = 1'b0;
        fire_x_d    = fire_x_q;
        fire_y_d    = fire_y_q;
        step        = 1'b0;
        descend     = 1'b0;

        live_cnt = '0;
        for (int unsigned i = 0; i < NUM_SHIPS_P; i++) live_cnt = live_cnt + 32'(alive_q[i]);
        // Written as a compare so the subtraction never goes negative.
        if (FRAMES_PER_STEP_P >= MIN_FRAMES_P + (NUM_SHIPS_P - live_cnt))
            period = FRAMES_PER_STEP_P - (NUM_SHIPS_P - live_cnt);
        else
            period = MIN_FRAMES_P;

        case (state_q)
            ST_IDLE, ST_LANDED, ST_CLEARED: begin
                if (start_i) begin
                    state_d     = ST_RIGHT;
                    left_d      = LEFT_START_P;
                    top_d       = TOP_START_P;
                    alive_d     = '1;
                    frame_cnt_d = '0;
                    fire_cnt_d  = '0;
                    fire_ptr_d  = '0;
                end
            end
            ST_RIGHT, ST_LEFT: begin
                alive_d = alive_q & ~hit_i;
                if (frame_i) begin
                    if (32'(frame_cnt_q) + 32'd1 >= period) begin
                        frame_cnt_d = '0;
                        step        = 1'b1;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end
                    if (fire_cnt_q == FIRE_DELAY_P - 16'd1) begin
                        fire_cnt_d = '0;
                        if (|alive_d) begin
                            fire_d     = 1'b1;
                            fire_x_d   = pix_t'(32'(left_q) + 32'(first_idx) * PITCH + SHIP_W_P / 2);
                            fire_y_d   = bot;
                            fire_ptr_d = (32'(first_idx) == NUM_SHIPS_P - 1) ? '0 : first_idx + 1'b1;
                        end
                    end else begin
                        fire_cnt_d = fire_cnt_q + 16'd1;
                    end
                end
                if (step) begin
                    if (state_q == ST_RIGHT) begin
                        if (32'(left_q) + 32'(hi_idx) * PITCH + SHIP_W_P + STEP_X_P <= SCREEN_W_P - 1)
                            left_d = left_q + pix_t'(STEP_X_P);
                        else
                            descend = 1'b1;
                    end else begin
                        if (32'(left_q) + 32'(lo_idx) * PITCH >= STEP_X_P)
                            left_d = left_q - pix_t'(STEP_X_P);
                        else
                            descend = 1'b1;
                    end
                    if (descend) begin
                        top_d   = top_q + pix_t'(STEP_Y_P);
                        state_d = (state_q == ST_RIGHT) ? ST_LEFT : ST_RIGHT;
                        if (32'(top_d) + SHIP_H_P >= LAND_Y_P) state_d = ST_LANDED;
                    end
                end
                if (alive_d == '0) state_d = ST_CLEARED;
            end
            default: state_d = ST_IDLE;
        endcase

        landed_d   = (state_d == ST_LANDED);
        all_dead_d = (state_d == ST_CLEARED);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            left_q      <= LEFT_START_P;
            top_q       <= TOP_START_P;
            alive_q     <= '0;
            frame_cnt_q <= '0;
            fire_cnt_q  <= '0;
            fire_ptr_q  <= '0;
            landed_q    <= 1'b0;
            all_dead_q  <= 1'b0;
            fire_q      <= 1'b0;
            fire_x_q    <= '0;
            fire_y_q    <= '0;
        end else begin
            state_q     <= state_d;
            left_q      <= left_d;
            top_q       <= top_d;
            alive_q     <= alive_d;
            frame_cnt_q <= frame_cnt_d;
            fire_cnt_q  <= fire_cnt_d;
            fire_ptr_q  <= fire_ptr_d;
            landed_q    <= landed_d;
            all_dead_q  <= all_dead_d;
            fire_q      <= fire_d;
            fire_x_q    <= fire_x_d;
            fire_y_q    <= fire_y_d;
        end
    end

    assign left_pos_o = left_q;
    assign top_pos_o  = top_q;
    assign bot_pos_o  = bot;
    assign alive_o    = alive_q;
    assign landed_o   = landed_q;
    assign all_dead_o = all_dead_q;
    assign fire_o     = fire_q;
    assign fire_x_o   = fire_x_q;
    assign fire_y_o   = fire_y_q;
    assign red_o      = COLOR_P[11:8];
    assign green_o    = COLOR_P[7:4];
    assign blue_o     = COLOR_P[3:0];

endmodule

// File: tb/tb_enemy_row.sv
// Directed bench for enemy_row with default parameters and hand-computed expectations.
module tb_enemy_row;

    logic       clk_i = 1'b0;
    logic       reset_n_i;
    logic       frame_i;
    logic       start_i;
    logic [7:0] hit_i;
    logic [9:0] left_pos_o, top_pos_o, bot_pos_o, fire_x_o, fire_y_o;
    logic [7:0] alive_o;
    logic       landed_o, all_dead_o, fire_o;
    logic [3:0] red_o, green_o, blue_o;

    int vectors     = 0;
    int miscompares = 0;
    int fire_seen   = 0;
    int nfire       = 0;

    always #5 clk_i = ~clk_i;

    enemy_row u_dut (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .frame_i    (frame_i),
        .start_i    (start_i),
        .hit_i      (hit_i),
        .left_pos_o (left_pos_o),
        .top_pos_o  (top_pos_o),
        .bot_pos_o  (bot_pos_o),
        .alive_o    (alive_o),
        .landed_o   (landed_o),
        .all_dead_o (all_dead_o),
        .fire_o     (fire_o),
        .fire_x_o   (fire_x_o),
        .fire_y_o   (fire_y_o),
        .red_o      (red_o),
        .green_o    (green_o),
        .blue_o     (blue_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
        if (fire_o) fire_seen++;
    endtask

    task automatic frames(input int unsigned n);
        frame_i = 1'b1;
        repeat (n) tick;
        frame_i = 1'b0;
    endtask

    task automatic pulse_start;
        start_i = 1'b1;
        tick;
        start_i = 1'b0;
    endtask

    task automatic hit(input logic [7:0] h);
        hit_i = h;
        tick;
        hit_i = '0;
    endtask

    initial begin
        reset_n_i = 1'b0;
        frame_i   = 1'b0;
        start_i   = 1'b0;
        hit_i     = '0;
        repeat (3) tick;
        check("rst_alive", alive_o, 8'h00);
        check("rst_left", left_pos_o, 9);
        check("rst_top", top_pos_o, 9);
        check("rst_bot", bot_pos_o, 19);
        check("rst_flags", {landed_o, all_dead_o, fire_o}, 3'b000);
        check("colour", {red_o, green_o, blue_o}, 12'hFFF);
        reset_n_i = 1'b1;
        tick;

        // Launch and first step
        pulse_start;
        check("start_alive", alive_o, 8'hFF);
        check("start_left", left_pos_o, 9);
        check("start_top", top_pos_o, 9);
        frames(29);
        check("pre_step_left", left_pos_o, 9);
        frames(1);
        check("step1_left", left_pos_o, 19);
        check("step1_top", top_pos_o, 9);
        pulse_start;
        check("start_ignored_left", left_pos_o, 19);
        check("start_ignored_alive", alive_o, 8'hFF);

        // Right edge bounce with the full row
        frames(16 * 30);
        check("edge_left", left_pos_o, 179);
        check("edge_top", top_pos_o, 9);
        frames(30);
        check("bounce_top", top_pos_o, 19);
        check("bounce_left", left_pos_o, 179);
        frames(30);
        check("move_left", left_pos_o, 169);

        // Keep bouncing until the row lands
        frame_i = 1'b1;
        for (int i = 0; i < 40000 && !landed_o; i++) tick;
        frame_i = 1'b0;
        check("landed", landed_o, 1);
        check("land_top", top_pos_o, 439);
        check("land_left", left_pos_o, 179);
        check("land_bot", bot_pos_o, 449);
        fire_seen = 0;
        frames(100);
        check("land_frozen_top", top_pos_o, 439);
        check("land_frozen_left", left_pos_o, 179);
        check("land_no_fire", fire_seen, 0);
        pulse_start;
        check("restart_alive", alive_o, 8'hFF);
        check("restart_top", top_pos_o, 9);
        check("restart_left", left_pos_o, 9);
        check("restart_landed", landed_o, 0);

        // Outer ship killed: period 29, bounce six steps later
        hit(8'h80);
        check("hit7_alive", alive_o, 8'h7F);
        frames(28);
        check("p29_pre_left", left_pos_o, 9);
        frames(1);
        check("p29_step_left", left_pos_o, 19);
        frames(29 * 22);
        check("late_edge_left", left_pos_o, 239);
        check("late_edge_top", top_pos_o, 9);
        frames(29);
        check("late_bounce_top", top_pos_o, 19);
        check("late_bounce_left", left_pos_o, 239);

        // Clearing by hits while moving left
        hit(8'h7F);
        check("clear_alive", alive_o, 8'h00);
        check("clear_flag", all_dead_o, 1);
        fire_seen = 0;
        frames(60);
        check("clear_no_fire", fire_seen, 0);
        check("clear_frozen_left", left_pos_o, 239);

        // Last kill coincides with a step
        pulse_start;
        check("restart2_dead", all_dead_o, 0);
        for (int i = 0; i < 7; i++) hit(8'(1 << i));
        check("one_left", alive_o, 8'h80);
        frames(22);
        check("p23_pre_left", left_pos_o, 9);
        frame_i = 1'b1;
        hit_i   = 8'h80;
        tick;
        frame_i = 1'b0;
        hit_i   = '0;
        check("last_kill_alive", alive_o, 8'h00);
        check("last_kill_dead", all_dead_o, 1);
        check("last_kill_step", left_pos_o, 19);
        fire_seen = 0;
        frames(200);
        check("dead_no_fire", fire_seen, 0);
        check("dead_frozen_left", left_pos_o, 19);

        // Round-robin fire over ships 2 and 5
        pulse_start;
        hit(8'hDB);
        check("pair_alive", alive_o, 8'h24);
        nfire   = 0;
        frame_i = 1'b1;
        for (int f = 1; f <= 180; f++) begin
            tick;
            if (fire_o) nfire++;
            if (f == 60) begin
                check("fire1_pulse", fire_o, 1);
                check("fire1_x", fire_x_o, 169);
                check("fire1_y", fire_y_o, 19);
            end
            if (f == 61) begin
                check("fire1_drop", fire_o, 0);
                check("fire1_hold_x", fire_x_o, 169);
            end
            if (f == 120) begin
                check("fire2_pulse", fire_o, 1);
                check("fire2_x", fire_x_o, 369);
            end
            if (f == 180) begin
                check("fire3_pulse", fire_o, 1);
                check("fire3_x", fire_x_o, 219);
            end
        end
        frame_i = 1'b0;
        check("fire_count", nfire, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
